// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the slice-serial flag subtractor.
// Optional add mode is enabled by defining SERIAL_SUB_ADD_EN.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_SLICE  = 4;
  localparam int DEF_NSLICE = DEF_WIDTH / DEF_SLICE;

  // Width of a counter that indexes n slices; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [cnt_width(DEF_NSLICE)-1:0] slice_cnt_t;

endpackage

// File: rtl/slice_adder.sv
// Combinational SLICE-bit ripple adder that also exposes the carry into its MSB,
// so the last slice can supply the signed-overflow flag. Requires SLICE >= 2.
module slice_adder #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE-1:0] w_low;
  logic             w_a_msb;
  logic             w_b_msb;

  // Low SLICE-1 bits are added one bit wider so the top bit is the carry into the MSB.
  assign w_low   = {1'b0, a[SLICE-2:0]} + {1'b0, b[SLICE-2:0]} + {{(SLICE-1){1'b0}}, cin};
  assign w_a_msb = a[SLICE-1];
  assign w_b_msb = b[SLICE-1];
  assign c_msb   = w_low[SLICE-1];

  assign sum  = {w_a_msb ^ w_b_msb ^ c_msb, w_low[SLICE-2:0]};
  assign cout = (w_a_msb & w_b_msb) | (c_msb & (w_a_msb ^ w_b_msb));

endmodule

// File: rtl/serial_flag_sub.sv
// Slice-serial WIDTH-bit subtractor producing N/V/Z/C behind a start/done handshake.
// Define SERIAL_SUB_ADD_EN to add the op_add port (1 = a+b, 0 = a-b).
module serial_flag_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SERIAL_SUB_ADD_EN
  input  logic             op_add,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             overflow,
  output logic             zero,
  output logic             carry
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = cnt_width(NSLICE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b;
  logic [WIDTH-SLICE-1:0] r_work;
  logic                   r_cin;
  logic [CNT_W-1:0]       r_cnt;
  logic [WIDTH-1:0]       r_result;
  logic                   r_n;
  logic                   r_v;
  logic                   r_z;
  logic                   r_c;

  logic             w_op_add;
  logic             w_accept;
  logic             w_last;
  logic [SLICE-1:0] w_sum;
  logic             w_cout;
  logic             w_c_msb;
  logic [WIDTH-1:0] w_res_nxt;

`ifdef SERIAL_SUB_ADD_EN
  assign w_op_add = op_add;
`else
  assign w_op_add = 1'b0;
`endif

  assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last    = (r_state == RUN) && (r_cnt == LAST_CNT);
  // Each new slice enters at the top; after NSLICE shifts the LSB slice sits at bit 0.
  assign w_res_nxt = {w_sum, r_work};

  slice_adder #(.SLICE(SLICE)) u_slice_adder (
    .a     (r_a[SLICE-1:0]),
    .b     (r_b[SLICE-1:0]),
    .cin   (r_cin),
    .sum   (w_sum),
    .cout  (w_cout),
    .c_msb (w_c_msb)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = RUN;
      RUN:     if (w_last)   w_state_nxt = DONE;
      DONE:    w_state_nxt = w_accept ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (r_state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // NOTE: the operand and work registers are reset too (not left don't-care),
  // so a reset mid-run leaves no partial result anywhere in the datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_work   <= '0;
      r_cin    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_n      <= 1'b0;
      r_v      <= 1'b0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= w_op_add ? b : ~b;
      r_cin <= ~w_op_add;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a    <= r_a >> SLICE;
      r_b    <= r_b >> SLICE;
      r_cin  <= w_cout;
      r_work <= w_res_nxt[WIDTH-1:SLICE];
      r_cnt  <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_result <= w_res_nxt;
        r_n      <= w_res_nxt[WIDTH-1];
        r_v      <= w_c_msb ^ w_cout;
        r_z      <= (w_res_nxt == '0);
        r_c      <= w_cout;
      end
    end
  end

  assign result   = r_result;
  assign negative = r_n;
  assign overflow = r_v;
  assign zero     = r_z;
  assign carry    = r_c;

endmodule

// File: tb/tb_serial_flag_sub.sv
// Self-checking bench for serial_flag_sub: directed cases plus randomized operands
// against an arithmetic reference model. Define SERIAL_SUB_ADD_EN to exercise add mode.
module tb_serial_flag_sub;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op_add;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        negative;
  logic        overflow;
  logic        zero;
  logic        carry;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_exp = '0;

  serial_flag_sub dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
`ifdef SERIAL_SUB_ADD_EN
    .op_add   (op_add),
`endif
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .negative (negative),
    .overflow (overflow),
    .zero     (zero),
    .carry    (carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Flags derived from plain integer arithmetic: unsigned range for C, signed range for V.
  task automatic model(input logic [31:0] x, input logic [31:0] y, input logic add,
                       output logic [31:0] r, output logic n, output logic v,
                       output logic z, output logic c);
    longint sx, sy, ux, uy, s;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    if (add) begin
      r = x + y;
      c = (ux + uy) > 64'd4294967295;
      s = sx + sy;
    end else begin
      r = x - y;
      c = (ux >= uy);
      s = sx - sy;
    end
    v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    n = r[31];
    z = (r == 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [31:0] x, input logic [31:0] y,
                              input logic add);
    logic [31:0] r;
    logic n, v, z, c;
    model(x, y, add, r, n, v, z, c);
    check({tag, "_res"}, 64'(result), 64'(r));
    check({tag, "_n"}, 64'(negative), 64'(n));
    check({tag, "_v"}, 64'(overflow), 64'(v));
    check({tag, "_z"}, 64'(zero), 64'(z));
    check({tag, "_c"}, 64'(carry), 64'(c));
    last_exp = r;
  endtask

  // Presents one request and returns at the falling edge after the accepting edge (RUN cycle 0).
  task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic add);
    @(negedge clk);
    a      = x;
    b      = y;
    op_add = add;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    a      = $urandom;
    b      = $urandom;
    op_add = 1'($urandom);
  endtask

  // Counts falling edges from RUN cycle `already` until done; scrambles a/b meanwhile
  // and requires the outputs to hold the previous result until done.
  task automatic wait_done(input int already, output int lat);
    logic hold_bad;
    hold_bad = 1'b0;
    lat      = -1;
    for (int i = already; i < 40; i++) begin
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      if (result !== last_exp) hold_bad = 1'b1;
      @(negedge clk);
      a = $urandom;
      b = $urandom;
    end
    check("hold_in_run", 64'(hold_bad), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic add);
    int lat;
    start_op(x, y, add);
    wait_done(0, lat);
    check({tag, "_lat"}, 64'(lat), 64'd8);
    check_result(tag, x, y, add);
    @(negedge clk);
    check({tag, "_done_w"}, 64'(done), 64'd0);
  endtask

  initial begin
    int          lat;
    logic        seen;
    logic        add;
    logic [31:0] x, y;

    reset  = 1'b1;
    start  = 1'b0;
    op_add = 1'b0;
    a      = '0;
    b      = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_res", 64'(result), 64'd0);
    check("rst_flags", 64'({negative, overflow, zero, carry}), 64'd0);
    reset = 1'b0;

    run_op("a5_b7", 32'd5, 32'd7, 1'b0);
    run_op("min_m1", 32'h8000_0000, 32'd1, 1'b0);
    run_op("equal", 32'h1234_5678, 32'h1234_5678, 1'b0);
    run_op("zero_zero", 32'd0, 32'd0, 1'b0);

    // A start in RUN cycle 3 must be ignored.
    start_op(32'd100, 32'd1, 1'b0);
    repeat (3) @(negedge clk);
    a = 32'd1; b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(4, lat);
    check("ign_lat", 64'(lat), 64'd8);
    check_result("ign", 32'd100, 32'd1, 1'b0);
    @(negedge clk);
    check("ign_no_second", 64'(busy), 64'd0);

    // Back-to-back: new request presented during the done cycle.
    start_op(32'h10, 32'h3, 1'b0);
    wait_done(0, lat);
    check("b2b1_lat", 64'(lat), 64'd8);
    check_result("b2b1", 32'h10, 32'h3, 1'b0);
    a = 32'h7FFF_FFFF; b = 32'hFFFF_FFFF; op_add = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_done_drop", 64'(done), 64'd0);
    check("b2b_busy", 64'(busy), 64'd1);
    wait_done(0, lat);
    check("b2b2_lat", 64'(lat), 64'd8);
    check_result("b2b2", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);

    // Reset in RUN cycle 4 discards the operation.
    start_op(32'hDEAD_BEEF, 32'h0123_4567, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_res", 64'(result), 64'd0);
    check("mid_rst_flags", 64'({negative, overflow, zero, carry}), 64'd0);
    last_exp = '0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check("mid_rst_no_done", 64'(seen), 64'd0);

`ifdef SERIAL_SUB_ADD_EN
    run_op("add_wrap", 32'hFFFF_FFFF, 32'd1, 1'b1);
    run_op("add_ovf", 32'h7FFF_FFFF, 32'd1, 1'b1);
`endif

    for (int i = 0; i < 40; i++) begin
      x   = $urandom;
      y   = (i % 8 == 0) ? x : 32'($urandom);
      add = 1'b0;
`ifdef SERIAL_SUB_ADD_EN
      add = 1'($urandom);
`endif
      run_op("rnd", x, y, add);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
